bitty_mem_arbiter: RTL and testbench
====================================

# bitty_mem_arbiter

Arbitrates the single-port 256×16 instruction memory between two requesters.
- Port F: the fetch path of the bitty sequencer. Read-only.
- Port H: a host/loader. Read/write, used for program load and debug peek/poke.

The block sits between both requesters and the memory instance. It grants at most one access per cycle and returns read data with one-cycle latency. It guarantees bounded host wait and lets the host lock out fetch during program load.

## Interface

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- STARVE_MAX, 3, consecutive cycles a pending host request may lose before it is forced to win (≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held until f_gnt
- f_addr  in  ADDR_W  fetch address; sampled in the f_gnt cycle
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  f_rdata valid (one cycle after f_gnt)
- f_rdata  out  DATA_W  fetch read data
- h_req  in  1  host request; held until h_gnt
- h_we  in  1  host write (1) / read (0)
- h_lock  in  1  host requests exclusive ownership
- h_addr  in  ADDR_W  host address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  host request accepted this cycle
- h_rvalid  out  1  h_rdata valid
- h_rdata  out  DATA_W  host read data
- mem_addr  out  ADDR_W  to memory
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory synchronous read data (valid one cycle after address)
- locked  out  1  block is in LOCK state

## Operation

State machine, 2 states:
- ARB (reset state)
  - Only f_req → fetch wins.
  - Only h_req → host wins.
  - Both asserted → fetch wins, unless starve_cnt == STARVE_MAX, in which case host wins.
  - Host granted with h_lock=1 → next state LOCK.
- LOCK
  - f_gnt is forced 0.
  - Host is granted whenever h_req=1.
  - h_lock sampled 0 → next state ARB. The host may still be granted in that cycle.
- locked = (state == LOCK), registered.

Starvation counter starve_cnt, width clog2(STARVE_MAX+1):
- Increments each cycle h_req=1 and h_gnt=0, saturating at STARVE_MAX.
- Clears on h_gnt or h_req=0.
- Held at 0 in LOCK.

Memory drive (combinational from the winner):
- mem_addr = winner address; with no winner, mem_addr holds its last registered value.
- mem_we = h_gnt & h_we.
- mem_wdata = h_wdata.

Read return:
- f_rvalid ← f_gnt, registered.
- h_rvalid ← h_gnt & ~h_we, registered.
- f_rdata = f_rvalid ? mem_rdata : 0.
- h_rdata = h_rvalid ? mem_rdata : 0.
- Host writes produce no rvalid.

Ordering:
- A host write to address A granted in cycle N is visible to any read granted in cycle N+1 or later.
- A fetch to A granted in cycle N-1 returns the old data.

## Timing

- Grant is zero-latency: f_gnt/h_gnt are combinational from requests and registered state in the same cycle.
- f_gnt and h_gnt are never both 1.
- Read latency is exactly 1 cycle: gnt in N → rvalid in N+1.
- Back-to-back grants are allowed every cycle. Sustained throughput is 1 access/cycle.
- A requester must keep req, addr, we and wdata stable until its gnt. Deasserting req before gnt withdraws the request, with no side effects.
- Reset (synchronous, applied at edge with reset=1):
  - state=ARB, starve_cnt=0, mem_addr=0, locked=0.
  - f_rvalid=0, h_rvalid=0, hence rdata=0.
  - While reset=1, f_gnt, h_gnt and mem_we are forced 0.
- Reset during LOCK returns to ARB; no pending read returns rvalid after reset.
- h_lock=1 with h_req=0 has no effect.

## Test plan

- Fetch only: f_req=1, f_addr=0x00..0x03 on consecutive cycles, memory preloaded with word = addr+0x100 → f_gnt every cycle; f_rdata 0x0100..0x0103 with f_rvalid one cycle later each.
- Contention with STARVE_MAX=3: f_req and h_req (read 0x10) held together → fetch granted cycles 0–2; h_gnt in cycle 3; h_rvalid in cycle 4; starve_cnt back to 0.
- Write-then-fetch: h write 0xBEEF to 0x20 granted in cycle N; fetch 0x20 granted in N+1 → f_rdata=0xBEEF in N+2.
- Lock: host write with h_lock=1 → locked=1 next cycle; f_req held for 8 cycles with f_gnt=0; h_lock dropped → locked=0 next cycle; fetch granted that cycle.
- Reset in LOCK with read outstanding: reset asserted the cycle after h_gnt(read) → h_rvalid=0, locked=0, all grants 0 during reset; normal arbitration resumes the cycle after reset deasserts.
- Withdrawal: h_req pulsed 1 cycle while losing to fetch → no h_gnt, no mem_we, starve_cnt cleared.

Source files
------------

// File: rtl/bitty_mem_arbiter_if.sv
// Bundle of requester-side handshakes and the memory-side bus for the
// bitty instruction-memory arbiter.
interface bitty_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              h_req;
  logic              h_we;
  logic              h_lock;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              locked;

  modport slave (
    input  f_req, f_addr, h_req, h_we, h_lock, h_addr, h_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, h_gnt, h_rvalid, h_rdata,
           mem_addr, mem_we, mem_wdata, locked
  );

  modport master (
    output f_req, f_addr, h_req, h_we, h_lock, h_addr, h_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, h_gnt, h_rvalid, h_rdata,
           mem_addr, mem_we, mem_wdata, locked
  );
endinterface

// File: rtl/bitty_mem_arbiter.sv
// Two-port arbiter (fetch read-only, host read/write) for a single-port
// synchronous memory; fetch-priority with bounded host starvation and host lock.
module bitty_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  bitty_mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              f_rvalid_q, h_rvalid_q;
  logic              f_gnt, h_gnt, host_prio;
  logic              f_rvalid, h_rvalid;

  assign host_prio = (starve_q == CNT_W'(STARVE_MAX));

  always_comb begin
    f_gnt = 1'b0;
    h_gnt = 1'b0;
    if (!reset_i) begin
      if (state_q == ST_LOCK) begin
        h_gnt = bus.h_req;
      end else begin
        h_gnt = bus.h_req & (~bus.f_req | host_prio);
        f_gnt = bus.f_req & ~h_gnt;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_ARB) begin
      if (h_gnt && bus.h_lock) state_d = ST_LOCK;
    end else if (!bus.h_lock) begin
      state_d = ST_ARB;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_LOCK || !bus.h_req || h_gnt) starve_d = '0;
    else if (!host_prio)                           starve_d = starve_q + CNT_W'(1);
  end

  // Idle cycles keep the last address so the memory sees no spurious change.
  always_comb begin
    addr_d = addr_q;
    if (h_gnt)      addr_d = bus.h_addr;
    else if (f_gnt) addr_d = bus.f_addr;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_ARB;
      starve_q   <= '0;
      addr_q     <= '0;
      f_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      f_rvalid_q <= f_gnt;
      h_rvalid_q <= h_gnt & ~bus.h_we;
    end
  end

  // A read granted just before reset must not surface while reset is held.
  assign f_rvalid = f_rvalid_q & ~reset_i;
  assign h_rvalid = h_rvalid_q & ~reset_i;

  assign bus.f_gnt     = f_gnt;
  assign bus.h_gnt     = h_gnt;
  assign bus.f_rvalid  = f_rvalid;
  assign bus.h_rvalid  = h_rvalid;
  assign bus.f_rdata   = f_rvalid ? bus.mem_rdata : '0;
  assign bus.h_rdata   = h_rvalid ? bus.mem_rdata : '0;
  assign bus.mem_addr  = addr_d;
  assign bus.mem_we    = h_gnt & bus.h_we;
  assign bus.mem_wdata = bus.h_wdata;
  assign bus.locked    = (state_q == ST_LOCK);
endmodule

// File: tb/tb_bitty_mem_arbiter.sv
// Directed bench for bitty_mem_arbiter: stimulus pushes expected read data,
// a negedge monitor pops and compares whenever an rvalid appears.
module tb_bitty_mem_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic init  = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;
  exp_t fq[$];
  exp_t hq[$];
  exp_t fe, he;

  logic [15:0] mem [256];

  bitty_mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  bitty_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_MAX(3)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory model, preloaded with word = addr + 0x100.
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i + 16'h0100);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.f_req  = 1'b0;
    bus.h_req  = 1'b0;
    bus.h_we   = 1'b0;
    bus.h_lock = 1'b0;
  endtask

  task automatic push_f(input logic [15:0] d);
    fq.push_back('{d: d, c: cyc + 1});
  endtask

  task automatic push_h(input logic [15:0] d);
    hq.push_back('{d: d, c: cyc + 1});
  endtask

  // Fetch and host read held together: fetch wins three cycles, host the fourth.
  task automatic contend(input logic [7:0] fa, input logic [7:0] ha, input logic [15:0] hd);
    for (int k = 0; k < 4; k++) begin
      cyc_start();
      bus.f_req = 1'b1; bus.f_addr = fa + 8'(k);
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_lock = 1'b0; bus.h_addr = ha;
      samp();
      if (k < 3) begin
        chk("cont_f_gnt", bus.f_gnt, 1);
        chk("cont_h_gnt", bus.h_gnt, 0);
        push_f(16'h0100 + 16'(fa) + 16'(k));
      end else begin
        chk("starve_h_gnt", bus.h_gnt, 1);
        chk("starve_f_gnt", bus.f_gnt, 0);
        chk("starve_mem_addr", bus.mem_addr, ha);
        push_h(hd);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.f_rvalid) begin
      if (fq.size() == 0) begin
        checks++; errors++;
        $display("FAIL f_rvalid: got unexpected rvalid want none (cycle %0d)", cyc);
      end else begin
        fe = fq.pop_front();
        chk("f_rdata", bus.f_rdata, fe.d);
        chk("f_rvalid_cycle", cyc, fe.c);
      end
    end else begin
      chk("f_rdata_idle", bus.f_rdata, 0);
    end
    if (bus.h_rvalid) begin
      if (hq.size() == 0) begin
        checks++; errors++;
        $display("FAIL h_rvalid: got unexpected rvalid want none (cycle %0d)", cyc);
      end else begin
        he = hq.pop_front();
        chk("h_rdata", bus.h_rdata, he.d);
        chk("h_rvalid_cycle", cyc, he.c);
      end
    end else begin
      chk("h_rdata_idle", bus.h_rdata, 0);
    end
  end

  initial begin
    idle();
    bus.f_addr = '0; bus.h_addr = '0; bus.h_wdata = '0;

    // Reset with requests present: nothing may be granted or written.
    bus.f_req = 1'b1; bus.h_req = 1'b1; bus.h_we = 1'b1;
    samp();
    chk("rst_f_gnt", bus.f_gnt, 0);
    chk("rst_h_gnt", bus.h_gnt, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    cyc_start(); idle();
    samp();
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_locked", bus.locked, 0);
    cyc_start(); reset = 1'b0; init = 1'b0;
    samp();
    chk("post_rst_locked", bus.locked, 0);

    // Fetch-only streaming.
    for (int a = 0; a < 4; a++) begin
      cyc_start(); bus.f_req = 1'b1; bus.f_addr = 8'(a);
      samp();
      chk("fetch_gnt", bus.f_gnt, 1);
      chk("fetch_mem_addr", bus.mem_addr, a);
      push_f(16'h0100 + 16'(a));
    end
    cyc_start(); idle();
    samp();
    chk("idle_mem_addr_hold", bus.mem_addr, 8'h03);

    // Contention, then a fresh host request must lose again (counter cleared).
    contend(8'h04, 8'h10, 16'h0110);
    cyc_start(); bus.f_addr = 8'h07; bus.h_addr = 8'h11;
    samp();
    chk("recleared_f_gnt", bus.f_gnt, 1);
    chk("recleared_h_gnt", bus.h_gnt, 0);
    push_f(16'h0107);
    cyc_start(); idle();

    // Host write 0x20 then fetch 0x20 next cycle sees new data.
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 8'h20; bus.h_wdata = 16'hBEEF;
    samp();
    chk("wr_h_gnt", bus.h_gnt, 1);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", bus.mem_addr, 8'h20);
    chk("wr_mem_wdata", bus.mem_wdata, 16'hBEEF);
    cyc_start(); idle(); bus.f_req = 1'b1; bus.f_addr = 8'h20;
    samp();
    chk("raw_f_gnt", bus.f_gnt, 1);
    push_f(16'hBEEF);

    // Fetch one cycle before a write returns the old word.
    cyc_start(); bus.f_addr = 8'h21;
    samp();
    push_f(16'h0121);
    cyc_start(); idle(); bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 8'h21; bus.h_wdata = 16'h1234;
    samp();
    chk("wr2_mem_we", bus.mem_we, 1);
    cyc_start(); idle(); bus.f_req = 1'b1; bus.f_addr = 8'h21;
    samp();
    push_f(16'h1234);

    // Lock: host write with h_lock, then fetch is held off for 8 cycles.
    cyc_start(); idle();
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_lock = 1'b1; bus.h_addr = 8'h30; bus.h_wdata = 16'hCAFE;
    samp();
    chk("lock_h_gnt", bus.h_gnt, 1);
    chk("lock_locked_pre", bus.locked, 0);
    for (int j = 1; j <= 8; j++) begin
      cyc_start();
      bus.h_req = (j == 2); bus.h_we = 1'b0; bus.h_lock = 1'b1;
      bus.f_req = 1'b1; bus.f_addr = 8'h30;
      samp();
      chk("lock_locked", bus.locked, 1);
      chk("lock_f_gnt", bus.f_gnt, 0);
      if (j == 2) begin
        chk("lock_host_read_gnt", bus.h_gnt, 1);
        push_h(16'hCAFE);
      end
    end
    cyc_start(); bus.h_req = 1'b0; bus.h_lock = 1'b0;
    samp();
    chk("unlock_locked_still", bus.locked, 1);
    chk("unlock_f_gnt_held", bus.f_gnt, 0);
    cyc_start();
    samp();
    chk("unlock_locked", bus.locked, 0);
    chk("unlock_f_gnt", bus.f_gnt, 1);
    push_f(16'hCAFE);

    // Reset in LOCK with a host read outstanding.
    cyc_start(); idle();
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_lock = 1'b1; bus.h_addr = 8'h01;
    samp();
    chk("rl_h_gnt", bus.h_gnt, 1);
    cyc_start(); idle(); reset = 1'b1; bus.f_req = 1'b1; bus.f_addr = 8'h02;
    samp();
    chk("rl_h_rvalid", bus.h_rvalid, 0);
    chk("rl_f_gnt", bus.f_gnt, 0);
    chk("rl_h_gnt", bus.h_gnt, 0);
    cyc_start(); reset = 1'b0;
    samp();
    chk("rl_locked", bus.locked, 0);
    chk("rl_resume_f_gnt", bus.f_gnt, 1);
    push_f(16'h0102);

    // Withdrawal: a one-cycle losing host write leaves no trace.
    cyc_start(); idle();
    bus.f_req = 1'b1; bus.f_addr = 8'h50;
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 8'h40; bus.h_wdata = 16'hDEAD;
    samp();
    chk("wd_f_gnt", bus.f_gnt, 1);
    chk("wd_h_gnt", bus.h_gnt, 0);
    chk("wd_mem_we", bus.mem_we, 0);
    push_f(16'h0150);
    cyc_start(); idle();
    contend(8'h51, 8'h40, 16'h0140);

    cyc_start(); idle();
    repeat (3) samp();
    chk("f_queue_drained", fq.size(), 0);
    chk("h_queue_drained", hq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
